// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl: ramps three 8-bit PWM levels toward a commanded colour, updating
// only at PWM period boundaries. Optional build macro: RGB_FADE_PREEMPT_EN.
module rgb_fade_ctrl #(
  parameter int PERIOD   = 256,
  parameter int STEP_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_target,
  input  logic [7:0]  cmd_step,
  output logic [7:0]  level_r,
  output logic [7:0]  level_g,
  output logic [7:0]  level_b,
  output logic        frame_tick,
  output logic        busy,
  output logic        done
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  // Moves one channel toward its target by at most step; 9-bit differences
  // keep the move from overshooting or wrapping past 0/255.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
    logic [8:0] diff;
    logic [7:0] res;
    diff = 9'd0;
    res  = cur;
    if (step == 8'd0) begin
      res = tgt;
    end else if (cur < tgt) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      if (diff > {1'b0, step}) begin
        res = cur + step;
      end else begin
        res = tgt;
      end
    end else if (cur > tgt) begin
      diff = {1'b0, cur} - {1'b0, tgt};
      if (diff > {1'b0, step}) begin
        res = cur - step;
      end else begin
        res = tgt;
      end
    end else begin
      res = cur;
    end
    return res;
  endfunction

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [DW-1:0] div_r;
  logic [23:0]   tgt_r;
  logic [7:0]    step_r;
  logic [7:0]    red_r;
  logic [7:0]    grn_r;
  logic [7:0]    blu_r;
  logic          done_r;

  logic          ready_s;
  logic          busy_s;
  logic          accept_s;
  logic          step_tick_s;
  logic          update_s;
  logic          all_eq_s;
  logic          finish_s;
  logic [7:0]    red_nxt_s;
  logic [7:0]    grn_nxt_s;
  logic [7:0]    blu_nxt_s;

  assign frame_tick  = (cnt_r == CNT_LAST);
  assign step_tick_s = frame_tick & (div_r == DIV_LAST);
  assign accept_s    = cmd_valid & ready_s;
  assign update_s    = (state_r == RAMP) & step_tick_s;

  assign red_nxt_s = step_toward(red_r, tgt_r[23:16], step_r);
  assign grn_nxt_s = step_toward(grn_r, tgt_r[15:8],  step_r);
  assign blu_nxt_s = step_toward(blu_r, tgt_r[7:0],   step_r);

  assign all_eq_s = (red_nxt_s == tgt_r[23:16]) & (grn_nxt_s == tgt_r[15:8]) &
                    (blu_nxt_s == tgt_r[7:0]);
  // A command accepted on the completing tick supersedes the fade, so no done.
  assign finish_s = update_s & all_eq_s & ~accept_s;

  // Free-running PWM frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (frame_tick) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Frame divider; cleared on accept so the first update is STEP_DIV frames out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r <= '0;
    end else if (accept_s) begin
      div_r <= '0;
    end else if (frame_tick) begin
      if (div_r == DIV_LAST) begin
        div_r <= '0;
      end else begin
        div_r <= div_r + {{(DW-1){1'b0}}, 1'b1};
      end
    end else begin
      div_r <= div_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = RAMP;
        end else begin
          state_s = IDLE;
        end
      end
      RAMP: begin
        if (accept_s) begin
          state_s = RAMP;
        end else if (finish_s) begin
          state_s = IDLE;
        end else begin
          state_s = RAMP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    ready_s = 1'b1;
    busy_s  = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
      RAMP: begin
`ifdef RGB_FADE_PREEMPT_EN
        ready_s = 1'b1;
`else
        ready_s = 1'b0;
`endif
        busy_s  = 1'b1;
      end
      default: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Command latch. On a coincident step tick the update still uses the old
  // target/step because the levels sample tgt_r/step_r before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tgt_r  <= 24'd0;
      step_r <= 8'd0;
    end else if (accept_s) begin
      tgt_r  <= cmd_target;
      step_r <= cmd_step;
    end else begin
      tgt_r  <= tgt_r;
      step_r <= step_r;
    end
  end

  // Channel levels change only on the frame wrap edge of a step tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      red_r <= 8'd0;
      grn_r <= 8'd0;
      blu_r <= 8'd0;
    end else if (update_s) begin
      red_r <= red_nxt_s;
      grn_r <= grn_nxt_s;
      blu_r <= blu_nxt_s;
    end else begin
      red_r <= red_r;
      grn_r <= grn_r;
      blu_r <= blu_r;
    end
  end

  // Completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_r <= 1'b0;
    end else begin
      done_r <= finish_s;
    end
  end

  assign cmd_ready = ready_s;
  assign busy      = busy_s;
  assign done      = done_r;
  assign level_r   = red_r;
  assign level_g   = grn_r;
  assign level_b   = blu_r;

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Directed bench for rgb_fade_ctrl with PERIOD=4, STEP_DIV=2; a tiny frame/divider
// model tells the bench which clock edge is a step tick.
module tb_rgb_fade_ctrl;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_target;
  logic [7:0]  cmd_step;
  logic [7:0]  level_r;
  logic [7:0]  level_g;
  logic [7:0]  level_b;
  logic        frame_tick;
  logic        busy;
  logic        done;

  int n_checks;
  int n_errors;
  int mcnt;
  int mdiv;
  bit tick_edge;

  rgb_fade_ctrl #(.PERIOD(4), .STEP_DIV(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .level_r    (level_r),
    .level_g    (level_g),
    .level_b    (level_b),
    .frame_tick (frame_tick),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock, negedge to negedge, updating the frame/divider model.
  task automatic step_clk(input bit acc);
    tick_edge = (mcnt == 3) && (mdiv == 1);
    if (acc) mdiv = 0;
    else if (mcnt == 3) mdiv = (mdiv + 1) % 2;
    mcnt = (mcnt + 1) % 4;
    @(negedge clk);
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      step_clk(1'b0);
      seen = tick_edge;
    end
    if (!seen) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_cmd(input logic [23:0] tgt, input logic [7:0] stp);
    cmd_valid  = 1'b1;
    cmd_target = tgt;
    cmd_step   = stp;
    check("send_ready", {31'd0, cmd_ready}, 32'd1);
    step_clk(1'b1);
    cmd_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic check_levels(input string tag, input int r, input int g, input int b);
    check({tag, "_r"}, {24'd0, level_r}, r);
    check({tag, "_g"}, {24'd0, level_g}, g);
    check({tag, "_b"}, {24'd0, level_b}, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_target = 24'd0;
    cmd_step   = 8'd0;
    mcnt       = 0;
    mdiv       = 0;
    tick_edge  = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check_levels("rst", 0, 0, 0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step_clk(1'b0);
      check("frame_tick", {31'd0, frame_tick}, (mcnt == 3) ? 32'd1 : 32'd0);
    end

    // Mid-frame reset clears the counter at once
    for (int i = 0; i < 3; i++) step_clk(1'b0);
    check("tick_before_rst", {31'd0, frame_tick}, 32'd1);
    reset = 1'b0;
    #1;
    check("tick_async_rst", {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    mcnt = 0;
    mdiv = 0;
    for (int i = 0; i < 3; i++) step_clk(1'b0);
    check("tick_after_rst", {31'd0, frame_tick}, 32'd1);
    step_clk(1'b0);

    // Fade to {40,0,255} by 16
    send_cmd(24'h2800FF, 8'd16);
    check("ramp_ready", {31'd0, cmd_ready}, 32'd0);
    for (int k = 1; k <= 16; k++) begin
      wait_tick();
      check_levels("ramp", (16 * k < 40) ? 16 * k : 40, 0, (k < 16) ? 16 * k : 255);
      check("ramp_done", {31'd0, done}, (k == 16) ? 32'd1 : 32'd0);
      check("ramp_busy", {31'd0, busy}, (k < 16) ? 32'd1 : 32'd0);
`ifndef RGB_FADE_PREEMPT_EN
      if (k == 2) begin
        cmd_valid  = 1'b1;
        cmd_target = 24'h000000;
        cmd_step   = 8'd0;
      end
      if (k >= 2 && k < 16) check("blocked_ready", {31'd0, cmd_ready}, 32'd0);
`endif
    end

    // Jump to black with step 0; accept at count 0, divider 0
`ifdef RGB_FADE_PREEMPT_EN
    send_cmd(24'h000000, 8'd0);
`else
    check("ready_after_done", {31'd0, cmd_ready}, 32'd1);
    step_clk(1'b1);
    cmd_valid = 1'b0;
    check("held_cmd_accepted", {31'd0, busy}, 32'd1);
`endif
    for (int i = 1; i <= 7; i++) begin
      step_clk(1'b0);
      if (i < 7) begin
        check("jump_hold_r", {24'd0, level_r}, 32'd40);
        check("jump_hold_done", {31'd0, done}, 32'd0);
      end else begin
        check_levels("jump", 0, 0, 0);
        check("jump_done", {31'd0, done}, 32'd1);
      end
    end
    step_clk(1'b0);
    check("done_pulse_end", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Target equal to current levels
    send_cmd(24'h000000, 8'd5);
    wait_tick();
    check_levels("same", 0, 0, 0);
    check("same_done", {31'd0, done}, 32'd1);
    check("same_busy", {31'd0, busy}, 32'd0);
    step_clk(1'b0);

`ifdef RGB_FADE_PREEMPT_EN
    // Preempt mid-ramp: reverses from current levels, first fade never completes
    send_cmd(24'hC86432, 8'd16);
    wait_tick();
    wait_tick();
    check_levels("pre_up", 32, 32, 32);
    send_cmd(24'h000000, 8'd16);
    wait_tick();
    check_levels("pre_down", 16, 16, 16);
    check("pre_no_done", {31'd0, done}, 32'd0);
    wait_tick();
    check_levels("pre_end", 0, 0, 0);
    check("pre_done", {31'd0, done}, 32'd1);
    step_clk(1'b0);
`endif

    // Reset mid-fade at level_r=32
    send_cmd(24'hC86432, 8'd16);
    wait_tick();
    wait_tick();
    check_levels("pre_rst", 32, 32, 32);
    step_clk(1'b0);
    step_clk(1'b0);
    reset = 1'b0;
    #1;
    check_levels("async_rst", 0, 0, 0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("async_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    mcnt = 0;
    mdiv = 0;
    for (int i = 0; i < 12; i++) begin
      step_clk(1'b0);
      check("no_done_after_rst", {31'd0, done}, 32'd0);
      check("lvl_after_rst", {24'd0, level_r}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rgb_fade_ctrl.md
Name: rgb_fade_ctrl

Overview:
- Sequencer for the three 8-bit PWM channels (R, G, B) of the mixer.
- Accepts a target colour over a valid/ready command interface and ramps each channel level toward its target in bounded steps.
- Level updates happen only at PWM period boundaries, so no PWM period ever sees a mid-period level change.
- Outputs drive the level inputs of three pwm instances.

Parameters:
PERIOD, 256, PWM period in clk cycles; must equal the pwm counter period; frame counter counts 0..PERIOD-1
STEP_DIV, 4, frames between successive level updates (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge clk
cmd_target  in  24  {R[23:16], G[15:8], B[7:0]} target levels
cmd_step  in  8  max per-update change per channel; 0 = jump straight to target
level_r  out  8  R channel level to pwm
level_g  out  8  G channel level to pwm
level_b  out  8  B channel level to pwm
frame_tick  out  1  one-cycle pulse when frame counter == PERIOD-1
busy  out  1  high while a fade is in progress
done  out  1  one-cycle pulse on the update that completes a fade

Behaviour:
- Reset (reset=0, asynchronous): frame counter=0, divider=0, state=IDLE, all levels=0, busy=0, done=0, cmd_ready=1, latched target/step=0.
- Frame counter: free-running 0..PERIOD-1 with wrap; never cleared by commands. frame_tick is combinational on count==PERIOD-1.
- Step tick: asserted on a frame_tick where divider==STEP_DIV-1. The divider increments on each frame_tick and wraps to 0 after STEP_DIV-1.
- On command acceptance, the divider is cleared to 0, so the first update lands on the STEP_DIV-th frame_tick after acceptance.
- States:
  - IDLE: cmd_ready=1, busy=0. On accept: latch target and step, clear divider, go to RAMP.
  - RAMP: cmd_ready=0, busy=1.
    - On each step tick, every channel updates: if level<target, level += min(step, target-level); if level>target, level -= min(step, level-target). step=0 means level=target.
    - Differences are computed in 9 bits; no overshoot, no wrap past 0 or 255.
    - If all three channels equal their targets after the update: done=1 for that cycle, go to IDLE.
- Update timing: levels register on the step-tick edge, i.e. the clock edge where frame counter goes from PERIOD-1 to 0. The new level is therefore valid from pwm count 0.
- Target equal to current levels: the fade still runs. done pulses at the first step tick and levels are unchanged.
- cmd_valid while not ready: ignored, nothing latched. The command source holds cmd_target and cmd_step stable until accepted.
- Reset mid-fade: immediate return to the reset values; the fade is lost and done is not pulsed.
- Latency: acceptance to first level change = remaining cycles of the current frame + (STEP_DIV-1)*PERIOD.

Optional Feature:
RGB_FADE_PREEMPT_EN
- Defined:
  - cmd_ready=1 in RAMP as well as IDLE.
  - A command accepted in RAMP replaces target and step, clears the divider, and continues ramping from the current levels.
  - No done pulse for the preempted fade.
  - If acceptance coincides with a step tick, the update for that tick uses the old target/step; the new command takes effect from the next step tick.
- Undefined: cmd_ready=0 in RAMP; commands are blocked until IDLE.

Test Plan:
PERIOD=4, STEP_DIV=2 (step tick every 8 cycles at counter wrap):
- Reset release -> levels 0/0/0, busy=0, cmd_ready=1, frame_tick every 4th cycle. Assert reset mid-frame -> counter=0 immediately.
- Target {40,0,255}, step 16 -> R 16,32,40 and B 16..240,255 on successive step ticks. done pulses on the tick where B reaches 255, with R=40 and G=0. No overshoot.
- From {40,0,255}: target {0,0,0}, step 0 -> all levels 0 on the first step tick (8 cycles after accept if accepted at count 0 with divider 0). done on the same cycle.
- Target equal to current levels -> busy for one update interval, done at first tick, levels unchanged.
- Without macro: cmd_valid held during a RAMP with different data -> not accepted until IDLE, then accepted next cycle. With RGB_FADE_PREEMPT_EN: new target {0,0,0} mid-ramp -> ramp reverses from current levels, no done for the first fade.
- Assert reset (low) during RAMP at level_r=32 -> all levels 0 and busy 0 asynchronously, done never pulses.
